// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment display path:
// active-low segment glyphs, digit position encoding and the captured value.
package seven_seg_pkg;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  // Segments a, d and g: shown for any non-BCD nibble (10..15).
  localparam logic [6:0] SEG_ERR   = 7'b0110110;

  // Scan position; also the anode bit number (0 = rightmost).
  typedef logic [1:0] digit_idx_t;
  localparam digit_idx_t DIGIT_ONES     = 2'd0;
  localparam digit_idx_t DIGIT_TENS     = 2'd1;
  localparam digit_idx_t DIGIT_HUNDREDS = 2'd2;
  localparam digit_idx_t DIGIT_SIGN     = 2'd3;

  // One converted value as delivered by the bcd converter.
  typedef struct packed {
    logic       sign;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_value_t;

  // True when a nibble is not a decimal digit.
  function automatic logic is_bcd_err(logic [3:0] d);
    return (d > 4'd9);
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to active-low seven-segment glyph.
// Non-decimal nibbles map to the error glyph.
module seg7_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Glyph lookup; everything above 9 falls to the error pattern.
  always_comb begin
    seg_o = SEG_ERR;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/seven_segment_mux.sv
// Latches each value from the bcd converter into a shadow register and
// time-multiplexes it onto a 4-digit common-anode display
// (sign, hundreds, tens, ones). All pin outputs are registered.
//
// Handshake: data_ready is a qualifier only (no ready back-pressure). Every
// rising clock edge that sees data_ready=1 copies sign/digits into the
// shadow register; holding it high simply recaptures each cycle.
module seven_segment_mux
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sign,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       data_ready,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  // A divider of 1 still needs a 1-bit counter that is always at its last value.
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;
  bcd_value_t       shadow_q, shadow_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       dec_in;
  logic [6:0]       dec_seg;

  // Refresh counter: dwell REFRESH_DIV cycles per digit, then step the scan index.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Shadow capture: the display only ever sees this copy, never the live inputs.
  always_comb begin
    shadow_d = shadow_q;
    if (data_ready) begin
      shadow_d.sign     = sign;
      shadow_d.hundreds = hundreds;
      shadow_d.tens     = tens;
      shadow_d.ones     = ones;
    end
  end

  // Route the digit at the current scan position into the shared decoder.
  always_comb begin
    dec_in = 4'd0;
    case (idx_q)
      DIGIT_ONES:     dec_in = shadow_q.ones;
      DIGIT_TENS:     dec_in = shadow_q.tens;
      DIGIT_HUNDREDS: dec_in = shadow_q.hundreds;
      default:        dec_in = 4'd0;
    endcase
  end

  seg7_decoder u_dec (
    .bcd_i (dec_in),
    .seg_o (dec_seg)
  );

  // Next segment/anode values: leading-zero suppression, sign glyph, blanking.
  // A suppressed digit keeps its anode on with all segments dark; an error
  // nibble is always shown so a bad value is never hidden.
  always_comb begin
    seg_d = dec_seg;
    case (idx_q)
      DIGIT_TENS: begin
        if (!is_bcd_err(shadow_q.tens) &&
            (shadow_q.hundreds == 4'd0) && (shadow_q.tens == 4'd0)) begin
          seg_d = SEG_BLANK;
        end
      end
      DIGIT_HUNDREDS: begin
        if (shadow_q.hundreds == 4'd0) begin
          seg_d = SEG_BLANK;
        end
      end
      DIGIT_SIGN: begin
        seg_d = shadow_q.sign ? SEG_MINUS : SEG_BLANK;
      end
      default: seg_d = dec_seg;
    endcase
    an_d = blank ? 4'b1111 : ~(4'b0001 << idx_q);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= DIGIT_ONES;
      shadow_q <= '0;
      an_q     <= 4'b1111;
      seg_q    <= SEG_BLANK;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Bench for seven_segment_mux with a 4-cycle refresh divider.
module tb_seven_segment_mux;

  localparam int R = 4;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       sign;
  logic [3:0] hundreds, tens, ones;
  logic       data_ready;
  logic       blank;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  always #5 clk = ~clk;

  seven_segment_mux #(.REFRESH_DIV(R)) dut (
    .clk        (clk),
    .rst        (rst),
    .sign       (sign),
    .hundreds   (hundreds),
    .tens       (tens),
    .ones       (ones),
    .data_ready (data_ready),
    .blank      (blank),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Display described as: a decimal number shown right-aligned with its
  // significant digits only, a leading minus slot, and a time-slot scan
  // whose position is (cycles since reset / R) mod 4.
  localparam logic [6:0] GLYPH [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000};

  int         m_n = 0;
  logic       m_sign = 1'b0;
  int         m_h = 0, m_t = 0, m_o = 0;
  logic [3:0] m_an = 4'hF;
  logic [6:0] m_seg = 7'h7F;

  function automatic logic [6:0] glyph(input int d);
    if (d > 9) return 7'b0110110;
    return GLYPH[d];
  endfunction

  function automatic logic [6:0] ref_seg(input int pos);
    int dig [3];
    int sig;
    dig[0] = m_o; dig[1] = m_t; dig[2] = m_h;
    if (pos == 3) return m_sign ? 7'b0111111 : 7'b1111111;
    sig = (m_h != 0) ? 3 : ((m_t != 0) ? 2 : 1);
    if (pos < sig || dig[pos] > 9) return glyph(dig[pos]);
    return 7'b1111111;
  endfunction

  // One clock: advance the model from the inputs present at the edge,
  // then sample the DUT 1 time unit later and compare.
  task automatic tick();
    int pos;
    @(posedge clk);
    if (rst) begin
      m_n = 0; m_sign = 1'b0; m_h = 0; m_t = 0; m_o = 0;
      m_an = 4'hF; m_seg = 7'h7F;
    end else begin
      pos   = (m_n / R) % 4;
      m_seg = ref_seg(pos);
      m_an  = blank ? 4'hF : ~(4'b0001 << pos);
      m_n++;
      if (data_ready) begin
        m_sign = sign; m_h = int'(hundreds); m_t = int'(tens); m_o = int'(ones);
      end
    end
    #1;
    check("model_an", {3'b000, an}, {3'b000, m_an});
    check("model_seg", seg, m_seg);
    check("dp", {6'b0, dp}, 7'd1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic scramble_inputs();
    sign     = 1'($urandom_range(0, 1));
    hundreds = 4'($urandom_range(0, 15));
    tens     = 4'($urandom_range(0, 15));
    ones     = 4'($urandom_range(0, 15));
  endtask

  task automatic load(input logic s, input logic [3:0] h, input logic [3:0] t,
                      input logic [3:0] o);
    sign = s; hundreds = h; tens = t; ones = o;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    scramble_inputs();
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic            s;
    logic [3:0]      h;
    logic [3:0]      t;
    logic [3:0]      o;
    logic [3:0][6:0] exp;  // exp[0]=ones slot .. exp[3]=sign slot
  } vec_t;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] MI = 7'b0111111;
  localparam logic [6:0] ER = 7'b0110110;

  vec_t vecs [6];

  initial begin
    logic [3:0] seen;
    int         pos;

    vecs[0] = '{1'b1, 4'd1, 4'd6, 4'd2, {MI, 7'b1111001, 7'b0000010, 7'b0100100}};
    vecs[1] = '{1'b0, 4'd0, 4'd3, 4'd8, {BL, BL, 7'b0110000, 7'b0000000}};
    vecs[2] = '{1'b0, 4'd0, 4'd0, 4'd0, {BL, BL, BL, 7'b1000000}};
    vecs[3] = '{1'b0, 4'd0, 4'd0, 4'd5, {BL, BL, BL, 7'b0010010}};
    vecs[4] = '{1'b0, 4'hA, 4'd0, 4'hF, {BL, ER, 7'b1000000, ER}};
    vecs[5] = '{1'b1, 4'd0, 4'd0, 4'd7, {MI, BL, BL, 7'b1111000}};

    // Reset: two cycles held, then release.
    rst = 1'b1; data_ready = 1'b0; blank = 1'b0;
    sign = 1'b0; hundreds = 4'd0; tens = 4'd0; ones = 4'd0;
    tick();
    tick();
    check("rst_an", {3'b000, an}, 7'b0001111);
    check("rst_seg", seg, 7'b1111111);
    check("rst_dp", {6'b0, dp}, 7'd1);
    rst = 1'b0;
    #2;
    check("post_rst_hold_an", {3'b000, an}, 7'b0001111);
    tick();
    check("first_an", {3'b000, an}, 7'b0001110);
    check("first_seg", seg, 7'b1000000);

    // Table: load each value, then watch one full scan with live inputs changing.
    for (int i = 0; i < 6; i++) begin
      load(vecs[i].s, vecs[i].h, vecs[i].t, vecs[i].o);
      seen = 4'b0000;
      for (int k = 0; k < 4 * R; k++) begin
        tick();
        pos = -1;
        for (int p = 0; p < 4; p++)
          if (an == ~(4'b0001 << p)) pos = p;
        if (pos < 0) begin
          check("vec_an_onehot", {3'b000, an}, 7'b0001110);
        end else begin
          seen[pos] = 1'b1;
          check($sformatf("vec%0d_pos%0d_seg", i, pos), seg, vecs[i].exp[pos]);
        end
        scramble_inputs();
      end
      check($sformatf("vec%0d_all_slots", i), {3'b000, seen}, 7'b0001111);
    end

    // Blank mid-scan for 10 cycles; scan timing keeps running underneath.
    load(1'b1, 4'd9, 4'd8, 4'd7);
    for (int k = 0; k < 3; k++) tick();
    blank = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("blank_an", {3'b000, an}, 7'b0001111);
    end
    blank = 1'b0;
    for (int k = 0; k < 12; k++) tick();

    // Reset mid-scan with an error-pattern value loaded.
    load(1'b0, 4'hA, 4'd0, 4'hF);
    for (int k = 0; k < 6; k++) tick();
    rst = 1'b1;
    tick();
    check("midrst_an", {3'b000, an}, 7'b0001111);
    check("midrst_seg", seg, 7'b1111111);
    rst = 1'b0;
    tick();
    check("midrst_first_an", {3'b000, an}, 7'b0001110);
    check("midrst_shadow_zero", seg, 7'b1000000);
    for (int k = 0; k < 16; k++) tick();

    // Randomized traffic checked against the model every cycle.
    for (int k = 0; k < 400; k++) begin
      scramble_inputs();
      data_ready = ($urandom_range(0, 3) == 0);
      blank      = ($urandom_range(0, 9) == 0);
      rst        = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0; blank = 1'b0; data_ready = 1'b0;
    for (int k = 0; k < 8; k++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
